dac_spi_driver: RTL and testbench

- Downstream stage of the waveform/FM top level; consumes its registered 8-bit `signal` output.
- Decimates it to a fixed sample rate and serialises each sample into a 16-bit SPI frame for an external 8-bit serial DAC.
- Frame format: 2 pad bits, 2 mode bits (normal operation), 8 data bits, 4 don't-care bits.
- Flags dropped samples when the sample rate exceeds the frame rate.

---
 rtl/dac_spi_driver_if.sv | 22 ++
 rtl/dac_spi_driver.sv | 133 +++++++++++++
 tb/tb_dac_spi_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_driver_if.sv
// Sample-in / SPI-out bundle of the DAC serialiser.
// The master modport is the driver; the slave modport is the sample source and DAC side.
interface dac_spi_driver_if;
  logic       enable;
  logic [7:0] signal;
  logic       sclk;
  logic       sync_n;
  logic       din;
  logic       busy;
  logic       sample_strobe;
  logic       overrun;

  modport master (
    input  enable, signal,
    output sclk, sync_n, din, busy, sample_strobe, overrun
  );

  modport slave (
    output enable, signal,
    input  sclk, sync_n, din, busy, sample_strobe, overrun
  );
endinterface

// File: rtl/dac_spi_driver.sv
// Decimates an 8-bit sample stream and serialises each accepted sample as a
// 16-bit SPI frame {pad, mode, data, don't-care}, flagging samples dropped while busy.
module dac_spi_driver #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SAMPLE_DIV = 200
) (
  input logic              clk,
  input logic              rst,
  dac_spi_driver_if.master bus
);
  localparam int unsigned   TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [7:0]    PHASE_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    phase_q, phase_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          sync_n_q, sync_n_d;
  logic          din_q, din_d;
  logic          busy_q, busy_d;
  logic          strobe_q, strobe_d;
  logic          overrun_q, overrun_d;
  logic          tick_s;
  logic          phase_wrap_s;
  logic [15:0]   frame_s;

  assign tick_s       = (tick_cnt_q == TICK_LAST);
  assign phase_wrap_s = (phase_q == PHASE_LAST);
  assign frame_s      = {2'b00, 2'b00, bus.signal, 4'b0000};

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sclk_d     = sclk_q;
    sync_n_d   = sync_n_q;
    din_d      = din_q;
    strobe_d   = 1'b0;
    tick_cnt_d = tick_s ? {TW{1'b0}} : tick_cnt_q + TW'(1);
    // A tick that finds the engine busy is dropped, never queued.
    overrun_d  = overrun_q | (tick_s & bus.enable & busy_q);
    case (state_q)
      IDLE: begin
        if (tick_s && bus.enable) begin
          shift_d   = frame_s[14:0];
          din_d     = frame_s[15];
          sync_n_d  = 1'b0;
          strobe_d  = 1'b1;
          bit_cnt_d = 5'd0;
          phase_d   = 8'd0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!phase_wrap_s) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = 8'd0;
          sclk_d  = ~sclk_q;
          // The DAC samples on the falling edge; din only moves on the rising edge.
          if (sclk_q) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else if (bit_cnt_q == 5'd16) begin
            sync_n_d = 1'b1;
            din_d    = 1'b0;
            state_d  = GAP;
          end else begin
            din_d   = shift_q[14];
            shift_d = {shift_q[13:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (phase_wrap_s) begin
          phase_d = 8'd0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        din_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= {TW{1'b0}};
      phase_q    <= 8'd0;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 15'd0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sclk_q     <= sclk_d;
      sync_n_q   <= sync_n_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.sclk          = sclk_q;
  assign bus.sync_n        = sync_n_q;
  assign bus.din           = din_q;
  assign bus.busy          = busy_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_dac_spi_driver.sv
// Three driver instances (CLK_DIV/SAMPLE_DIV = 2/80, 2/40, 1/34) share one stimulus and
// are compared each cycle against a frame-timing model derived from edge arithmetic.
module tb_dac_spi_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] sig = 8'hA5;
  int         n_checks = 0;
  int         n_errors = 0;

  int cd [3] = '{2, 2, 1};
  int sd [3] = '{80, 40, 34};

  // Measurements taken from the DUT outputs, cleared on every reset.
  int          first_strobe [3];
  int          n_strobe [3];
  int          n_frames [3];
  int          low_cnt [3];
  int          busy_cnt [3];
  int          low1 [3];
  int          busy1 [3];
  logic [15:0] cap [3];
  logic [15:0] cap1 [3];
  logic [15:0] cap2 [3];

  dac_spi_driver_if bus0 ();
  dac_spi_driver_if bus1 ();
  dac_spi_driver_if bus2 ();

  assign bus0.enable = en;
  assign bus0.signal = sig;
  assign bus1.enable = en;
  assign bus1.signal = sig;
  assign bus2.enable = en;
  assign bus2.signal = sig;

  dac_spi_driver #(.CLK_DIV(2), .SAMPLE_DIV(80)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dac_spi_driver #(.CLK_DIV(2), .SAMPLE_DIV(40)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dac_spi_driver #(.CLK_DIV(1), .SAMPLE_DIV(34)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Outputs after the j-th edge following an accepted sample; packed {sclk,sync_n,din,busy,strobe}.
  function automatic logic [4:0] frame_out(input int j, input int cdiv, input logic [15:0] fr);
    logic sclk_e, sync_e, din_e, busy_e, stb_e;
    sclk_e = 1'b1; sync_e = 1'b1; din_e = 1'b0; busy_e = 1'b0; stb_e = 1'b0;
    if (j >= 0 && j < 32 * cdiv) begin
      sync_e = 1'b0;
      busy_e = 1'b1;
      sclk_e = ((j / cdiv) % 2 == 0);
      din_e  = fr[15 - (j / (2 * cdiv))];
      stb_e  = (j == 0);
    end else if (j >= 32 * cdiv && j < 33 * cdiv) begin
      busy_e = 1'b1;
    end
    return {sclk_e, sync_e, din_e, busy_e, stb_e};
  endfunction

  initial begin : monitor
    int          e;
    int          t0 [3];
    logic [15:0] fr [3];
    logic        ovr [3];
    logic [5:0]  act [3];
    logic [5:0]  exp_v;
    logic        prev_sclk [3];
    logic        prev_busy [3];
    bit          started;
    started = 1'b0;
    e = 0;
    for (int i = 0; i < 3; i++) begin
      t0[i] = -1000000; fr[i] = 16'h0000; ovr[i] = 1'b0;
      prev_sclk[i] = 1'b1; prev_busy[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      act[0] = {bus0.sclk, bus0.sync_n, bus0.din, bus0.busy, bus0.sample_strobe, bus0.overrun};
      act[1] = {bus1.sclk, bus1.sync_n, bus1.din, bus1.busy, bus1.sample_strobe, bus1.overrun};
      act[2] = {bus2.sclk, bus2.sync_n, bus2.din, bus2.busy, bus2.sample_strobe, bus2.overrun};
      if (rst) begin
        started = 1'b1;
        e = 0;
        for (int i = 0; i < 3; i++) begin
          t0[i] = -1000000; ovr[i] = 1'b0;
          first_strobe[i] = -1; n_strobe[i] = 0; n_frames[i] = 0;
          low_cnt[i] = 0; busy_cnt[i] = 0; low1[i] = 0; busy1[i] = 0;
          cap[i] = 16'h0000; cap1[i] = 16'h0000; cap2[i] = 16'h0000;
        end
      end else if (started) begin
        e++;
        for (int i = 0; i < 3; i++) begin
          if ((e % sd[i]) == 0 && en) begin
            // Still busy if the previous frame's 33*CLK_DIV busy cycles have not all elapsed.
            if (e - t0[i] > 33 * cd[i]) begin
              t0[i] = e;
              fr[i] = {4'b0000, sig, 4'b0000};
            end else begin
              ovr[i] = 1'b1;
            end
          end
        end
      end
      if (started) begin
        for (int i = 0; i < 3; i++) begin
          exp_v = {frame_out(e - t0[i], cd[i], fr[i]), ovr[i]};
          n_checks++;
          if (act[i] !== exp_v) begin
            n_errors++;
            $display("FAIL outputs dut%0d edge %0d: got sclk,sync_n,din,busy,strobe,overrun=%b expected %b",
                     i, e, act[i], exp_v);
          end
          if (!rst) begin
            if (act[i][1]) begin
              n_strobe[i]++;
              if (first_strobe[i] < 0) first_strobe[i] = e;
              low_cnt[i] = 0; busy_cnt[i] = 0; cap[i] = 16'h0000;
            end
            if (!act[i][4]) low_cnt[i]++;
            if (act[i][2]) busy_cnt[i]++;
            if (prev_sclk[i] && !act[i][5] && !act[i][4]) cap[i] = {cap[i][14:0], act[i][3]};
            if (prev_busy[i] && !act[i][2]) begin
              n_frames[i]++;
              if (n_frames[i] == 1) begin
                cap1[i] = cap[i]; low1[i] = low_cnt[i]; busy1[i] = busy_cnt[i];
              end
              if (n_frames[i] == 2) cap2[i] = cap[i];
            end
          end
          prev_sclk[i] = act[i][5];
          prev_busy[i] = act[i][2];
        end
      end
    end
  end

  initial begin : stimulus
    // Scenarios 1, 2, 3 and 6 run concurrently on the three instances.
    rst = 1'b1; en = 1'b1; sig = 8'hA5;
    repeat (3) @(negedge clk);
    chk("reset sclk", int'(bus0.sclk), 1);
    chk("reset sync_n", int'(bus0.sync_n), 1);
    chk("reset busy", int'(bus0.busy), 0);
    #1 rst = 1'b0;
    repeat (90) @(negedge clk);
    #1 sig = 8'h3C;
    repeat (310) @(negedge clk);
    #1;
    chk("d0 first strobe edge", first_strobe[0], 80);
    chk("d0 frame1 bits", int'(cap1[0]), 16'h0A50);
    chk("d0 frame1 sync_n low cycles", low1[0], 64);
    chk("d0 frame1 busy cycles", busy1[0], 66);
    chk("d0 frame2 bits", int'(cap2[0]), 16'h03C0);
    chk("d0 overrun", int'(bus0.overrun), 0);
    chk("d1 first strobe edge", first_strobe[1], 40);
    chk("d1 strobes by edge 400", n_strobe[1], 5);
    chk("d1 overrun", int'(bus1.overrun), 1);
    chk("d2 first strobe edge", first_strobe[2], 34);
    chk("d2 strobes by edge 400", n_strobe[2], 11);
    chk("d2 frame1 sync_n low cycles", low1[2], 32);
    chk("d2 frame1 busy cycles", busy1[2], 33);
    chk("d2 overrun", int'(bus2.overrun), 0);

    // Scenario 4: reset in the middle of a frame.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; sig = 8'hA5;
    repeat (100) @(negedge clk);
    #1;
    chk("d0 busy before mid-frame reset", int'(bus0.busy), 1);
    chk("d1 overrun before reset", int'(bus1.overrun), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset sclk", int'(bus0.sclk), 1);
    chk("mid reset sync_n", int'(bus0.sync_n), 1);
    chk("mid reset din", int'(bus0.din), 0);
    chk("mid reset busy", int'(bus0.busy), 0);
    chk("mid reset overrun", int'(bus1.overrun), 0);
    #1 rst = 1'b0;
    repeat (90) @(negedge clk);
    #1;
    chk("d0 first strobe after reset", first_strobe[0], 80);

    // Scenario 5: enable held low until edge 100.
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("d0 no strobe while disabled", n_strobe[0], 0);
    chk("d1 no overrun while disabled", int'(bus1.overrun), 0);
    en = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("d0 first strobe after enable", first_strobe[0], 160);
    chk("d1 first strobe after enable", first_strobe[1], 120);
    chk("d2 first strobe after enable", first_strobe[2], 102);

    // Randomized traffic: new sample every cycle, slow enable changes, rare resets.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      sig = 8'($urandom);
      if ($urandom_range(0, 59) == 0) en = ~en;
      rst = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
